// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//  - FSM state encodings (2-bit, kept as plain constants for legacy users)
//  - BCD_ALL9: all-nines BCD pattern used for the saturated display value
//  - pow10: elaboration-time helper for the overflow limit
package bin_to_bcd_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Wide enough for up to 16 digits; users slice off the low 4*DIGITS bits.
  localparam logic [63:0] BCD_ALL9 = 64'h9999_9999_9999_9999;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Single-digit correction cell for the shift-and-add-3 algorithm.
// Ports:
//   d  in  4  BCD digit before the shift
//   q  out 4  d + 3 when d >= 5, else d (no carry out; 5..9 map to 8..12)
module bin_to_bcd_seq_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  always_comb begin
    q = d;
    if (d >= 4'd5) begin
      q = d + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock (shift-and-add-3).
// Feeds the 4-digit multiplexed 7-seg driver; bcd_out only changes on done,
// so the display never sees intermediate values.
// Ports:
//   clk        in   1         clock, posedge
//   rst        in   1         synchronous active-high reset
//   start      in   1         request conversion; sampled only while idle
//   is_signed  in   1         1: bin is two's complement
//   bin        in   WIDTH     operand, captured on the accepted start edge
//   busy       out  1         conversion in progress
//   done       out  1         one-cycle pulse, results just updated
//   bcd_out    out  4*DIGITS  packed BCD, units digit in [3:0]
//   neg        out  1         result negative (signed mode only)
//   ovf        out  1         magnitude > 10^DIGITS-1, bcd_out saturated to 9s
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ScrW = BcdW + WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam longint unsigned MaxMag = pow10(DIGITS) - 64'd1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ScrW-1:0]   scratch_q, scratch_d;
  logic              neg_i_q, neg_i_d;
  logic              ovf_i_q, ovf_i_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              neg_q, neg_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // Operand magnitude; the most negative value negates to 2^(WIDTH-1) exactly,
  // which still fits as a WIDTH-bit unsigned number.
  logic              neg_cap;
  logic [WIDTH-1:0]  mag;
  logic [63:0]       mag_ext;

  assign neg_cap = is_signed & bin[WIDTH-1];
  assign mag     = neg_cap ? (~bin + {{(WIDTH-1){1'b0}}, 1'b1}) : bin;
  assign mag_ext = 64'(mag);

  // Per-digit +3 correction, applied before each left shift.
  logic [BcdW-1:0] bcd_adj;
  logic [ScrW-1:0] scratch_adj;

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bin_to_bcd_seq_add3 u_add3 (
      .d (scratch_q[WIDTH + 4*i +: 4]),
      .q (bcd_adj[4*i +: 4])
    );
  end

  assign scratch_adj = {bcd_adj, scratch_q[WIDTH-1:0]};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    scratch_d = scratch_q;
    neg_i_d   = neg_i_q;
    ovf_i_d   = ovf_i_q;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          scratch_d = {{BcdW{1'b0}}, mag};
          neg_i_d   = neg_cap;
          ovf_i_d   = (mag_ext > 64'(MaxMag));
          cnt_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scratch_d = {scratch_adj[ScrW-2:0], 1'b0};
        cnt_d     = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d   = ovf_i_q ? BCD_ALL9[BcdW-1:0] : scratch_q[ScrW-1:WIDTH];
        neg_d   = neg_i_q;
        ovf_d   = ovf_i_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      scratch_q <= '0;
      neg_i_q   <= 1'b0;
      ovf_i_q   <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      scratch_q <= scratch_d;
      neg_i_q   <= neg_i_d;
      ovf_i_q   <= ovf_i_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (WIDTH=14, DIGITS=4).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        neg;
  logic        ovf;

  int n_total;
  int n_pass;

  bin_to_bcd_seq #(
    .WIDTH  (14),
    .DIGITS (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [13:0] b;
    logic [15:0] bcd;
    logic        n;
    logic        o;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits by division; returns {neg, ovf, bcd}.
  function automatic logic [17:0] model(input logic s, input logic [13:0] b);
    int          v;
    logic        n;
    logic        o;
    logic [15:0] d;
    n = s & b[13];
    v = n ? (16384 - int'(b)) : int'(b);
    o = (v > 9999);
    if (o) begin
      d = 16'h9999;
    end else begin
      d = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return {n, o, d};
  endfunction

  // Called at #1 after the start edge; returns edges until done (-1 on timeout).
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  // Called at #1 after a posedge while idle; returns in the done cycle.
  task automatic convert(input logic s, input logic [13:0] b, output int lat);
    is_signed = s;
    bin       = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bin   = ~b;  // later changes must not affect the result
    wait_done(lat);
  endtask

  initial begin
    int          lat;
    int          ndone;
    int          lat2;
    logic [17:0] exp;
    logic [15:0] held;
    logic        s;
    logic [13:0] b;

    n_total = 0;
    n_pass  = 0;

    vecs[0]  = '{1'b0, 14'd0,     16'h0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 14'd1234,  16'h1234, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 14'd9999,  16'h9999, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 14'd10000, 16'h9999, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 14'd16383, 16'h9999, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 14'h3FF6,  16'h0010, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 14'h2000,  16'h8192, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 14'h1FFF,  16'h8191, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 14'h3FF6,  16'h9999, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 14'd0,     16'h0000, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 14'h3FFF,  16'h0001, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 14'h2710,  16'h6384, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 14'd59,    16'h0059, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 14'd5,     16'h0005, 1'b0, 1'b0};

    rst       = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    bin       = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset bcd_out", 32'(bcd_out), 32'd0);
    check("reset neg", 32'(neg), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      convert(vecs[i].s, vecs[i].b, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd15);
      check($sformatf("vec%0d bcd_out", i), 32'(bcd_out), 32'(vecs[i].bcd));
      check($sformatf("vec%0d neg", i), 32'(neg), 32'(vecs[i].n));
      check($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].o));
      check($sformatf("vec%0d busy at done", i), 32'(busy), 32'd0);
      held = bcd_out;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
      check($sformatf("vec%0d bcd held", i), 32'(bcd_out), 32'(held));
    end

    // start re-pulsed mid-conversion (sampled at edges 3 and 10) is ignored.
    is_signed = 1'b0;
    bin       = 14'd1234;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    lat   = -1;
    held  = 16'h0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat  = k;
          held = bcd_out;
        end
      end
      if (k == 2 || k == 9) begin
        start = 1'b1;
        bin   = 14'd777;
      end
    end
    check("ignore-start done count", 32'(ndone), 32'd1);
    check("ignore-start latency", 32'(lat), 32'd15);
    check("ignore-start bcd_out", 32'(held), 32'h1234);

    // Synchronous reset at edge 7 aborts the conversion.
    bin   = 14'd9876;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      if (k == 7) rst = 1'b1;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort bcd_out", 32'(bcd_out), 32'd0);
    check("abort done", 32'(done), 32'd0);
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    convert(1'b0, 14'd42, lat);
    check("after abort latency", 32'(lat), 32'd15);
    check("after abort bcd_out", 32'(bcd_out), 32'h0042);

    // Back-to-back: start asserted in the done cycle is accepted.
    convert(1'b0, 14'd321, lat);
    check("b2b first latency", 32'(lat), 32'd15);
    check("b2b first bcd_out", 32'(bcd_out), 32'h0321);
    is_signed = 1'b0;
    bin       = 14'd4321;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b busy after accept", 32'(busy), 32'd1);
    wait_done(lat2);
    check("b2b second latency", 32'(lat2), 32'd15);
    check("b2b second bcd_out", 32'(bcd_out), 32'h4321);

    // Random sample in both modes against the division model.
    for (int i = 0; i < 300; i++) begin
      s = (i % 2 == 1);
      b = 14'($urandom_range(0, 16383));
      exp = model(s, b);
      convert(s, b, lat);
      check($sformatf("rand s=%0d b=%0d", s, b),
            32'({lat[7:0], neg, ovf, bcd_out}), 32'({8'd15, exp}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
